// File: rtl/simon_entry_checker_if.sv
// simon_entry_checker_if: round handshake between blinker/controller (master) and entry checker (slave).
// seq_data/seq_len/start flow toward the checker; busy/pass/fail flow back.
interface simon_entry_checker_if #(
  parameter int MAX_LEN = 8
);
  logic [2*MAX_LEN-1:0] seq_data;
  logic [3:0]           seq_len;
  logic                 start;
  logic                 busy;
  logic                 pass;
  logic                 fail;
  modport master (output seq_data, seq_len, start, input busy, pass, fail);
  modport slave (input seq_data, seq_len, start, output busy, pass, fail);
endinterface

// File: rtl/simon_entry_checker.sv
// simon_entry_checker: collects debounced Simon entries and checks them against the played sequence.
// Ports: CLOCK_50 clock; KEY[1] async active-low reset, KEY[0] active-low enter, KEY[3:2] unused;
// SW entered symbol; bus (slave) takes start/seq_data/seq_len and returns busy/pass/fail;
// LEDR = {pass latched, fail latched, thermometer of accepted count}; HEX0 = accepted count, active-low.
// Optional macro SIMON_TIMEOUT_EN: fail a round after TIMEOUT_CYC cycles waiting for press/release.
module simon_entry_checker #(
  parameter int DEBOUNCE_CYC = 6,
  parameter int MAX_LEN      = 8,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic                        CLOCK_50,
  input  logic [3:0]                  KEY,
  input  logic [1:0]                  SW,
  simon_entry_checker_if.slave        bus,
  output logic [9:0]                  LEDR,
  output logic [6:0]                  HEX0
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DEB = DW'(DEBOUNCE_CYC);
  typedef enum logic [2:0] {IDLE, WAIT_PRESS, CHECK, WAIT_RELEASE, PASS, FAIL} state_t;
  logic rst_n;
  logic unused_keys;
  assign rst_n = KEY[1];
  assign unused_keys = ^KEY[3:2];
  state_t state_q, state_d;
  logic sync_q, key_q, last_q;
  logic armed_q, armed_d;
  logic [DW-1:0] run_q, run_d;
  logic [2*MAX_LEN-1:0] seq_q, seq_d;
  logic [3:0] len_q, len_d, idx_q, idx_d, cnt_q, cnt_d;
  logic [1:0] sym_q, sym_d, exp_sym;
  logic pled_q, pled_d, fled_q, fled_d;
  logic hi_ok, lo_ok, accept, timeout;
  logic [7:0] therm;
  // Run length of identical synchronized samples, saturating at the debounce threshold.
  assign run_d = (key_q != last_q) ? DW'(1) : (run_q == DEB) ? run_q : run_q + 1'b1;
  assign hi_ok = key_q && run_d == DEB;
  assign lo_ok = !key_q && run_d == DEB;
  // armed means a debounced release has been seen since the last accepted press,
  // so a button still held from a previous round is not taken as a new entry.
  assign accept = state_q == WAIT_PRESS && armed_q && lo_ok;
  assign exp_sym = 2'(seq_q >> {idx_q, 1'b0});
`ifdef SIMON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;
  logic waiting;
  assign waiting = state_q == WAIT_PRESS || state_q == WAIT_RELEASE;
  assign timeout = waiting && to_q == TW'(TIMEOUT_CYC - 1);
  assign to_d = (state_d == WAIT_PRESS && state_q != WAIT_PRESS) ? '0 : waiting ? to_q + 1'b1 : to_q;
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) to_q <= '0;
    else to_q <= to_d;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    pled_d  = pled_q;
    fled_d  = fled_q;
    armed_d = hi_ok ? 1'b1 : armed_q;
    case (state_q)
      IDLE: if (bus.start && bus.seq_len != 4'd0) begin
        seq_d   = bus.seq_data;
        len_d   = (bus.seq_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : bus.seq_len;
        idx_d   = '0;
        cnt_d   = '0;
        pled_d  = 1'b0;
        fled_d  = 1'b0;
        state_d = WAIT_PRESS;
      end
      WAIT_PRESS: if (accept) begin
        sym_d   = SW;
        armed_d = 1'b0;
        state_d = CHECK;
      end else if (timeout) state_d = FAIL;
      CHECK: if (sym_q != exp_sym) state_d = FAIL;
      else begin
        cnt_d   = idx_q + 4'd1;
        idx_d   = (idx_q == len_q - 4'd1) ? idx_q : idx_q + 4'd1;
        state_d = (idx_q == len_q - 4'd1) ? PASS : WAIT_RELEASE;
      end
      WAIT_RELEASE: state_d = hi_ok ? WAIT_PRESS : timeout ? FAIL : WAIT_RELEASE;
      PASS: begin
        pled_d  = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        fled_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= 1'b1;
      key_q   <= 1'b1;
      last_q  <= 1'b1;
      armed_q <= 1'b0;
      run_q   <= '0;
      seq_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sym_q   <= '0;
      pled_q  <= 1'b0;
      fled_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= KEY[0];
      key_q   <= sync_q;
      last_q  <= key_q;
      armed_q <= armed_d;
      run_q   <= run_d;
      seq_q   <= seq_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      pled_q  <= pled_d;
      fled_q  <= fled_d;
    end
  assign bus.busy = state_q != IDLE;
  assign bus.pass = state_q == PASS;
  assign bus.fail = state_q == FAIL;
  always_comb
    for (int i = 0; i < 8; i++) therm[i] = 32'(cnt_q) > i;
  assign LEDR = {pled_q, fled_q, therm};
  always_comb
    case (cnt_q)
      4'd0:    HEX0 = 7'b1000000;
      4'd1:    HEX0 = 7'b1111001;
      4'd2:    HEX0 = 7'b0100100;
      4'd3:    HEX0 = 7'b0110000;
      4'd4:    HEX0 = 7'b0011001;
      4'd5:    HEX0 = 7'b0010010;
      4'd6:    HEX0 = 7'b0000010;
      4'd7:    HEX0 = 7'b1111000;
      4'd8:    HEX0 = 7'b0000000;
      default: HEX0 = 7'b1111111;
    endcase
endmodule

// File: tb/tb_simon_entry_checker.sv
// tb_simon_entry_checker: directed stimulus, event-level reference model, per-cycle output compare.
module tb_simon_entry_checker;
  localparam int DEB = 6;
  localparam int TMO = 50;
  logic clk = 1'b0;
  logic [3:0] KEY;
  logic [1:0] SW;
  logic [9:0] LEDR;
  logic [6:0] HEX0;
  int checks = 0, failures = 0, npass = 0, nfail = 0;
  bit chk_en = 0;
  logic [6:0] seg [0:8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
  always #5 clk = ~clk;
  simon_entry_checker_if #(.MAX_LEN(8)) bus ();
  simon_entry_checker #(.DEBOUNCE_CYC(DEB), .MAX_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .CLOCK_50(clk), .KEY(KEY), .SW(SW), .bus(bus), .LEDR(LEDR), .HEX0(HEX0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] therm(input int n);
    therm = '0;
    for (int i = 0; i < 8; i++) if (i < n) therm[i] = 1'b1;
  endfunction

  // Reference model: tracks what the player has done in terms of sample windows and
  // scheduled outcome cycles, not the design's internal state machine.
  int cyc = 0, pend_cyc, end_cyc, m_idx, m_len, m_cnt, pend_cnt, verdict, wcnt;
  bit m_busy, m_pass, m_fail, m_pl, m_fl, want_press, want_rel, need_rel, dl0, dl1;
  bit syn[$];
  logic [15:0] m_seq;
  always @(posedge clk or negedge KEY[1]) begin
    if (!KEY[1]) begin
      {m_busy, m_pass, m_fail, m_pl, m_fl, want_press, want_rel} = '0;
      m_cnt = 0; need_rel = 1; dl0 = 1; dl1 = 1; syn.delete();
      pend_cyc = -1; end_cyc = -1; wcnt = 0;
    end else begin
      bit s, lo, hi, go, acc, waiting;
      int e;
      cyc++;
      s = dl1; dl1 = dl0; dl0 = KEY[0];
      syn.push_back(s);
      if (syn.size() > DEB) void'(syn.pop_front());
      lo = syn.size() == DEB; hi = lo;
      foreach (syn[i]) begin lo &= !syn[i]; hi &= syn[i]; end
      waiting = want_press || want_rel;
      go = !m_busy && bus.start && bus.seq_len != 0;
      acc = 0; m_pass = 0; m_fail = 0;
      if (m_busy && end_cyc == cyc) begin
        m_busy = 0;
        if (verdict == 1) m_pl = 1; else m_fl = 1;
      end else if (m_busy && pend_cyc == cyc) begin
        m_cnt = pend_cnt;
        if (verdict == 1) begin m_pass = 1; end_cyc = cyc + 1; end
        else if (verdict == 2) begin m_fail = 1; end_cyc = cyc + 1; end
        else want_rel = 1;
      end else if (want_press && !need_rel && lo) begin
        acc = 1; want_press = 0; pend_cyc = cyc + 1;
        e = int'(m_seq[2*m_idx +: 2]);
        if (int'(SW) != e) begin verdict = 2; pend_cnt = m_idx; end
        else begin
          pend_cnt = m_idx + 1;
          if (m_idx + 1 == m_len) verdict = 1;
          else begin verdict = 0; m_idx++; end
        end
      end else if (want_rel && hi) begin
        want_rel = 0; want_press = 1; wcnt = -1;
      end
`ifdef SIMON_TIMEOUT_EN
      else if (waiting && wcnt == TMO - 1) begin
        want_press = 0; want_rel = 0; verdict = 2; m_fail = 1; end_cyc = cyc + 1;
      end
`endif
      if (waiting) wcnt++;
      if (hi) need_rel = 0;
      if (acc) need_rel = 1;
      if (go) begin
        m_busy = 1; want_press = 1; want_rel = 0; m_seq = bus.seq_data;
        m_len = (bus.seq_len > 8) ? 8 : int'(bus.seq_len);
        m_idx = 0; m_cnt = 0; m_pl = 0; m_fl = 0; pend_cyc = -1; end_cyc = -1; wcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("pass", 32'(bus.pass), 32'(m_pass));
      check("fail", 32'(bus.fail), 32'(m_fail));
      check("ledr", 32'(LEDR), 32'({m_pl, m_fl, therm(m_cnt)}));
      check("hex0", 32'(HEX0), 32'(seg[m_cnt]));
      npass += int'(bus.pass);
      nfail += int'(bus.fail);
    end
  end

  task automatic begin_round(input logic [15:0] d, input logic [3:0] l);
    bus.seq_data = d; bus.seq_len = l; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic press(input logic [1:0] sym);
    SW = sym; KEY[0] = 1'b0;
    repeat (10) @(negedge clk);
    KEY[0] = 1'b1; SW = ~sym;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int got, p0, f0;
    logic [15:0] d8;
    KEY = 4'b0001; SW = '0;
    bus.start = 1'b0; bus.seq_data = '0; bus.seq_len = '0;
    repeat (3) @(negedge clk);
    check("reset_ledr", 32'(LEDR), 32'(0));
    check("reset_hex0", 32'(HEX0), 32'(7'b1000000));
    check("reset_busy", 32'(bus.busy), 32'(0));
    KEY = 4'b0011; chk_en = 1;
    repeat (10) @(negedge clk);
    check("idle_hex0", 32'(HEX0), 32'(7'b1000000));
    begin_round(16'b10_01_11, 4'd0);
    @(negedge clk);
    check("len0_ignored", 32'(bus.busy), 32'(0));
    // Full match, with a stray start mid-round that must be ignored.
    p0 = npass;
    begin_round(16'b10_01_11, 4'd3);
    press(2'd3);
    begin_round(16'b00, 4'd1);
    press(2'd1);
    press(2'd2);
    check("match_pulses", 32'(npass - p0), 32'(1));
    check("match_ledr", 32'(LEDR), 32'(10'b10_00000111));
    check("match_hex0", 32'(HEX0), 32'(7'b0110000));
    // Mismatch on the second entry: fail two cycles after acceptance.
    f0 = nfail;
    begin_round(16'b10_01_11, 4'd3);
    press(2'd3);
    SW = 2'd0; KEY[0] = 1'b0; got = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.fail && got == 0) got = i;
    end
    KEY[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("mismatch_latency", 32'(got), 32'(9));
    check("mismatch_pulses", 32'(nfail - f0), 32'(1));
    check("mismatch_ledr", 32'(LEDR), 32'(10'b01_00000001));
    // Bounce then stable low: exactly one acceptance, count visible 9 negedges after the drive.
    begin_round(16'b10_01_11, 4'd3);
    SW = 2'd3;
    for (int b = 0; b < 5; b++) begin
      KEY[0] = 1'b0; repeat (3) @(negedge clk);
      KEY[0] = 1'b1; repeat (3) @(negedge clk);
    end
    check("bounce_none", 32'(LEDR[7:0]), 32'(0));
    KEY[0] = 1'b0; got = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (LEDR[0] && got == 0) got = i;
    end
    check("bounce_latency", 32'(got), 32'(9));
    check("bounce_one", 32'(LEDR[7:0]), 32'(8'b00000001));
    KEY[0] = 1'b1;
    repeat (10) @(negedge clk);
    // Reset mid-round: immediate reset values, no pulse.
    p0 = npass; f0 = nfail;
    KEY[1] = 1'b0;
    #1;
    check("midrst_ledr", 32'(LEDR), 32'(0));
    check("midrst_hex0", 32'(HEX0), 32'(7'b1000000));
    check("midrst_busy", 32'(bus.busy), 32'(0));
    repeat (3) @(negedge clk);
    KEY[1] = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_nopulse", 32'(npass - p0 + nfail - f0), 32'(0));
    // A press held across rounds must be released before it counts again.
    begin_round(16'b01, 4'd1);
    SW = 2'd1; KEY[0] = 1'b0;
    repeat (12) @(negedge clk);
    begin_round(16'b01, 4'd1);
    repeat (20) @(negedge clk);
    check("held_not_taken", 32'(LEDR[7:0]), 32'(0));
    KEY[0] = 1'b1;
    repeat (10) @(negedge clk);
    press(2'd1);
    check("held_then_pass", 32'(LEDR), 32'(10'b10_00000001));
    // Length above MAX_LEN is clamped to 8.
    d8 = 16'b00_01_10_11_11_10_01_00;
    begin_round(d8, 4'd9);
    for (int i = 0; i < 8; i++) press(d8[2*i +: 2]);
    check("clamp_ledr", 32'(LEDR), 32'(10'b10_11111111));
    check("clamp_hex0", 32'(HEX0), 32'(7'b0000000));
    // No presses at all.
    begin_round(16'b10_01_11, 4'd3);
`ifdef SIMON_TIMEOUT_EN
    got = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.fail && got == 0) got = i;
    end
    check("timeout_latency", 32'(got), 32'(51));
    check("timeout_ledr", 32'(LEDR[8]), 32'(1));
`else
    repeat (200) @(negedge clk);
    check("no_timeout_busy", 32'(bus.busy), 32'(1));
    KEY[1] = 1'b0;
    repeat (3) @(negedge clk);
    KEY[1] = 1'b1;
    repeat (5) @(negedge clk);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/simon_entry_checker.md
# simon_entry_checker

Player-input side of the Simon game. It takes the sequence the LED blinker has just played and collects the player's entries: a symbol on SW[1:0], confirmed by a press of KEY[0]. It debounces each press, checks every symbol against the expected one, and reports pass or fail. It sits beside the blinker: the blinker pulses `start` when playback ends, and this block returns the verdict to the game controller.

## Interface
- `DEBOUNCE_CYC`, 6: consecutive stable synchronized samples required to accept a press or a release.
- `MAX_LEN`, 8: maximum sequence length in symbols.
- `TIMEOUT_CYC`, 1000: idle cycles allowed between entries. Used only with `SIMON_TIMEOUT_EN`.
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `KEY`  in  4  KEY[1] is the reset: asynchronous, active-low. KEY[0] is the enter button, active-low. KEY[3:2] are unused.
- `SW`  in  2  symbol being entered, 0..3.
- `seq_data`  in  2*MAX_LEN  expected sequence; symbol i is at [2i+1:2i]. Sampled on `start`.
- `seq_len`  in  4  sequence length. Sampled on `start`.
- `start`  in  1  one-cycle pulse from the blinker; begins a round.
- `busy`  out  1  high while a round is in progress.
- `pass`  out  1  one-cycle pulse: the whole sequence was matched.
- `fail`  out  1  one-cycle pulse: mismatch, or timeout.
- `LEDR`  out  10  [9] pass latched, [8] fail latched, [7:0] thermometer of symbols accepted.
- `HEX0`  out  7  active-low 7-segment display of the accepted count.

## Operation
- KEY[0] passes through a 2-flop synchronizer. The debounce counter counts consecutive equal samples and clears on any change.
- States:
  - IDLE: on `start` with `seq_len`≠0, latch `seq_data` and min(`seq_len`, MAX_LEN), clear the index, clear LEDR[9:8], go to WAIT_PRESS. `start` with `seq_len`=0 is ignored.
  - WAIT_PRESS: after DEBOUNCE_CYC consecutive low samples, sample SW[1:0] and go to CHECK.
  - CHECK: one cycle.
    - Mismatch: go to FAIL.
    - Match and index = len−1: go to PASS.
    - Otherwise: increment the index and go to WAIT_RELEASE.
  - WAIT_RELEASE: after DEBOUNCE_CYC consecutive high samples, go to WAIT_PRESS.
  - PASS / FAIL: one cycle. Pulse the output, set LEDR[9] or LEDR[8], go to IDLE.
- `busy` is high in every state except IDLE.
- `start` is ignored while `busy` is high.
- The accepted count equals the index after CHECK; it counts the final symbol too.
  - HEX0 and LEDR[7:0] follow the accepted count.
  - The count clears on the next accepted `start`.
- A press held at the end of a round does not carry over: it is re-qualified only after a debounced release.

## Timing
- Reset (KEY[1] low) acts immediately and asynchronously:
  - state IDLE, counters 0;
  - `busy`=0, `pass`=0, `fail`=0;
  - LEDR=10'b0;
  - HEX0=7'b1000000 ("0");
  - synchronizer flops preset to 1.
- Reset mid-round aborts the round with no pass/fail pulse.
- Latency, counting from the first low synchronized sample as cycle 0:
  - symbol accepted at cycle DEBOUNCE_CYC−1;
  - CHECK on the next cycle;
  - `pass`/`fail` pulse one cycle after CHECK.
- A high sample during press debounce restarts the count from 0. Bounces shorter than DEBOUNCE_CYC are never accepted.
- SW is sampled only on the acceptance cycle. SW changes at any other time are ignored.

## Configuration
- Macro: `SIMON_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in WAIT_PRESS and WAIT_RELEASE. It clears on every state change into WAIT_PRESS.
  - When it reaches TIMEOUT_CYC the block goes to FAIL, with the same pulse and LEDR[8] behaviour as a mismatch.
- Undefined: no counter is built, and the block waits for a press indefinitely.

## Test plan
- Reset: drive KEY=4'b0001, then 4'b0011 → LEDR=0, HEX0=7'b1000000, `busy`=0.
- Full match: `start` with `seq_len`=3, `seq_data`=6'b10_01_11; enter 3, 1, 2 with clean presses of 10 cycles → `pass` pulses once, LEDR[9]=1, LEDR[7:0]=8'b00000111, HEX0 shows "3".
- Mismatch: same sequence, second entry SW=0 → `fail` pulses two cycles after acceptance, LEDR[8]=1, LEDR[7:0]=8'b00000001.
- Bounce: KEY[0] toggles low/high every 3 cycles for 30 cycles, then holds low → exactly one symbol accepted, with acceptance 6 cycles after the stable low begins (after sync).
- Reset mid-round: assert KEY[1] low after the first accepted symbol → all outputs at reset values, and no `pass`/`fail` pulse is seen.
- With `SIMON_TIMEOUT_EN` and TIMEOUT_CYC=50: `start` and no presses → `fail` pulses once, about 51 cycles after `start`; without the macro → `busy` stays 1.
